// File: rtl/i2c_txn_scheduler.sv
// Round-robin scheduler sharing one byte-level I2C engine between N_REQ requesters.
// Expands each granted transaction into engine commands and streams read bytes back.
module i2c_txn_scheduler #(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 4095
) (
  input  logic                     clk_4MHz,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_rw,
  input  logic [7*N_REQ-1:0]       req_dev,
  input  logic [8*N_REQ-1:0]       req_reg,
  input  logic [8*N_REQ-1:0]       req_wdata,
  input  logic [LEN_W*N_REQ-1:0]   req_len,
  output logic [N_REQ-1:0]         txn_done,
  output logic [1:0]               txn_status,
  output logic                     rd_valid,
  output logic [7:0]               rd_data,
  output logic                     rd_last,
  output logic [2:0]               rd_id,
  output logic                     eng_cmd_valid,
  input  logic                     eng_cmd_ready,
  output logic [2:0]               eng_cmd,
  output logic [7:0]               eng_wdata,
  input  logic                     eng_done,
  input  logic [7:0]               eng_rdata,
  input  logic                     eng_nack,
  output logic                     eng_abort
);

  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TC_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_START, S_DEVW, S_REG, S_DATA, S_RSTART, S_DEVR, S_READ, S_STOP, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    CMD_START = 3'd0, CMD_WRITE = 3'd1, CMD_READ_ACK = 3'd2,
    CMD_READ_NACK = 3'd3, CMD_STOP = 3'd4, CMD_RSTART = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {ST_OK = 2'd0, ST_NACK = 2'd1, ST_TIMEOUT = 2'd2} status_e;

  state_e              r_state, w_state_nxt;
  status_e             r_status, w_status_nxt;
  logic                r_wait, w_wait_nxt;
  logic [TC_W-1:0]     r_tcnt, w_tcnt_nxt;
  logic [ID_W-1:0]     r_ptr, r_grant, w_grant, w_idx;
  logic                w_found;
  logic                r_rw;
  logic [6:0]          r_dev;
  logic [7:0]          r_reg, r_wdata;
  logic [LEN_W-1:0]    r_cnt;
  logic                r_rd_valid, r_rd_last, r_abort;
  logic [7:0]          r_rd_data;
  logic                w_progress, w_read_done, w_timeout;

  // First pending requester strictly after the last winner, wrapping.
  always_comb begin
    w_grant = r_ptr;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      w_idx = ID_W'((32'(r_ptr) + i) % N_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_grant = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_4MHz) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_status <= ST_OK;
      r_wait   <= 1'b0;
      r_tcnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_status <= w_status_nxt;
      r_wait   <= w_wait_nxt;
      r_tcnt   <= w_tcnt_nxt;
    end
  end

  // Every command state has two phases: offer (r_wait=0) then await eng_done (r_wait=1).
  always_comb begin
    w_state_nxt   = r_state;
    w_status_nxt  = r_status;
    w_wait_nxt    = r_wait;
    w_tcnt_nxt    = r_tcnt;
    w_progress    = 1'b0;
    w_read_done   = 1'b0;
    w_timeout     = 1'b0;
    eng_cmd_valid = 1'b0;
    eng_cmd       = CMD_START;
    eng_wdata     = '0;
    txn_done      = '0;
    txn_status    = '0;

    case (r_state)
      S_IDLE: if (|req_valid) w_state_nxt = S_ARB;
      S_ARB: begin
        w_state_nxt  = S_START;
        w_status_nxt = ST_OK;
        w_wait_nxt   = 1'b0;
        w_tcnt_nxt   = '0;
      end
      S_DONE: begin
        txn_done[r_grant] = 1'b1;
        txn_status        = r_status;
        w_state_nxt       = S_IDLE;
      end
      default: begin
        eng_cmd_valid = !r_wait;
        case (r_state)
          S_START:  eng_cmd = CMD_START;
          S_DEVW:   begin eng_cmd = CMD_WRITE; eng_wdata = {r_dev, 1'b0}; end
          S_REG:    begin eng_cmd = CMD_WRITE; eng_wdata = r_reg; end
          S_DATA:   begin eng_cmd = CMD_WRITE; eng_wdata = r_wdata; end
          S_RSTART: eng_cmd = CMD_RSTART;
          S_DEVR:   begin eng_cmd = CMD_WRITE; eng_wdata = {r_dev, 1'b1}; end
          S_READ:   eng_cmd = (r_cnt != '0) ? CMD_READ_ACK : CMD_READ_NACK;
          default:  eng_cmd = CMD_STOP;
        endcase

        w_progress = r_wait ? eng_done : eng_cmd_ready;
        if (w_progress) begin
          w_tcnt_nxt = '0;
          w_wait_nxt = !r_wait;
          if (r_wait) begin
            case (r_state)
              S_START:  w_state_nxt = S_DEVW;
              S_RSTART: w_state_nxt = S_DEVR;
              S_READ: begin
                w_read_done = 1'b1;
                if (r_cnt == '0) w_state_nxt = S_STOP;
              end
              S_STOP:   w_state_nxt = S_DONE;
              default: begin
                if (eng_nack) begin
                  w_state_nxt  = S_STOP;
                  w_status_nxt = ST_NACK;
                end else begin
                  case (r_state)
                    S_DEVW:  w_state_nxt = S_REG;
                    S_REG:   w_state_nxt = r_rw ? S_RSTART : S_DATA;
                    S_DEVR:  w_state_nxt = S_READ;
                    default: w_state_nxt = S_STOP;
                  endcase
                end
              end
            endcase
          end
        end else if (r_tcnt == TC_W'(TIMEOUT_CYC - 1)) begin
          w_timeout    = 1'b1;
          w_status_nxt = ST_TIMEOUT;
          w_state_nxt  = S_DONE;
          w_wait_nxt   = 1'b0;
          w_tcnt_nxt   = '0;
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_4MHz) begin
    if (rst) begin
      r_ptr      <= ID_W'(N_REQ - 1);
      r_grant    <= '0;
      r_rw       <= 1'b0;
      r_dev      <= '0;
      r_reg      <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_last  <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      if (r_state == S_ARB) begin
        r_ptr   <= w_grant;
        r_grant <= w_grant;
        r_rw    <= req_rw[w_grant];
        r_dev   <= req_dev[w_grant*7 +: 7];
        r_reg   <= req_reg[w_grant*8 +: 8];
        r_wdata <= req_wdata[w_grant*8 +: 8];
        r_cnt   <= req_len[w_grant*LEN_W +: LEN_W];
      end else if (w_read_done && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      r_rd_valid <= w_read_done;
      if (w_read_done) begin
        r_rd_data <= eng_rdata;
        r_rd_last <= (r_cnt == '0);
      end
      r_abort <= w_timeout;
    end
  end

  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign rd_last   = r_rd_last;
  assign eng_abort = r_abort;
  assign rd_id     = (r_rd_valid || r_state == S_DONE) ? 3'(r_grant) : '0;

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Directed bench for i2c_txn_scheduler: a responsive engine model plus auto-dropping
// requesters, with hand-computed command, read-byte and completion expectations.
`timescale 1ns/1ps
module tb_i2c_txn_scheduler;
  localparam int unsigned N_REQ       = 2;
  localparam int unsigned LEN_W       = 4;
  localparam int unsigned TIMEOUT_CYC = 4095;

  logic                   clk_4MHz = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid, req_rw;
  logic [7*N_REQ-1:0]     req_dev;
  logic [8*N_REQ-1:0]     req_reg, req_wdata;
  logic [LEN_W*N_REQ-1:0] req_len;
  logic [N_REQ-1:0]       txn_done;
  logic [1:0]             txn_status;
  logic                   rd_valid, rd_last;
  logic [7:0]             rd_data;
  logic [2:0]             rd_id;
  logic                   eng_cmd_valid, eng_cmd_ready;
  logic [2:0]             eng_cmd;
  logic [7:0]             eng_wdata;
  logic                   eng_done, eng_nack, eng_abort;
  logic [7:0]             eng_rdata;

  i2c_txn_scheduler #(.N_REQ(N_REQ), .LEN_W(LEN_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_4MHz(clk_4MHz), .rst(rst),
    .req_valid(req_valid), .req_rw(req_rw), .req_dev(req_dev), .req_reg(req_reg),
    .req_wdata(req_wdata), .req_len(req_len),
    .txn_done(txn_done), .txn_status(txn_status),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_id(rd_id),
    .eng_cmd_valid(eng_cmd_valid), .eng_cmd_ready(eng_cmd_ready), .eng_cmd(eng_cmd),
    .eng_wdata(eng_wdata), .eng_done(eng_done), .eng_rdata(eng_rdata),
    .eng_nack(eng_nack), .eng_abort(eng_abort)
  );

  always #125 clk_4MHz = ~clk_4MHz;

  int cyc = 0;
  always @(posedge clk_4MHz) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Logs: cmd {cmd,wdata}; rd {id,last,data}; done {abort,id,status,done}.
  logic [10:0] cmd_q[$];
  int          cmd_t[$];
  logic [11:0] rd_q[$];
  logic [7:0]  done_q[$];
  int          done_t[$];
  int          abort_cnt;
  int          t_req;
  int          n_issue[N_REQ] = '{default: 0};
  int          n_done[N_REQ]  = '{default: 0};
  logic        pend, p_nack, nack_en;
  logic [7:0]  p_rdata, nack_byte;
  logic [N_REQ-1:0] nv;

  function automatic logic [31:0] outs();
    return {2'b00, txn_done, txn_status, rd_valid, rd_data, rd_last, rd_id,
            eng_cmd_valid, eng_cmd, eng_wdata, eng_abort};
  endfunction

  // Engine model and requesters: accept on valid&ready, return eng_done one cycle later.
  initial begin
    req_valid = '0; eng_done = 1'b0; eng_rdata = '0; eng_nack = 1'b0;
    pend = 1'b0; p_nack = 1'b0; p_rdata = '0; abort_cnt = 0; t_req = 0; nv = '0;
    forever begin
      @(negedge clk_4MHz);
      if (|txn_done) begin
        done_q.push_back({eng_abort, rd_id, txn_status, txn_done});
        done_t.push_back(cyc);
        for (int i = 0; i < N_REQ; i++) if (txn_done[i]) n_done[i]++;
      end
      if (rd_valid) rd_q.push_back({rd_id, rd_last, rd_data});
      if (eng_abort) abort_cnt++;
      eng_done = 1'b0; eng_nack = 1'b0; eng_rdata = '0;
      if (rst || eng_abort) begin
        pend = 1'b0;
      end else if (pend) begin
        eng_done = 1'b1; eng_rdata = p_rdata; eng_nack = p_nack; pend = 1'b0;
      end else if (eng_cmd_valid && eng_cmd_ready) begin
        p_rdata = 8'(32'h80 + cmd_q.size());
        p_nack  = nack_en && eng_cmd == 3'd1 && eng_wdata == nack_byte;
        cmd_q.push_back({eng_cmd, (eng_cmd == 3'd1) ? eng_wdata : 8'h00});
        cmd_t.push_back(cyc);
        pend = 1'b1;
      end
      for (int i = 0; i < N_REQ; i++) nv[i] = (n_done[i] < n_issue[i]);
      if (req_valid == '0 && nv != '0) t_req = cyc;
      req_valid = nv;
    end
  end

  task automatic set_req(input int i, input logic rw, input logic [6:0] dev,
                         input logic [7:0] rg, input logic [7:0] wd, input logic [LEN_W-1:0] len);
    req_rw[i]               = rw;
    req_dev[i*7 +: 7]       = dev;
    req_reg[i*8 +: 8]       = rg;
    req_wdata[i*8 +: 8]     = wd;
    req_len[i*LEN_W +: LEN_W] = len;
    n_issue[i]++;
  endtask

  task automatic wait_dones(input int target, input int budget, input string tag);
    int k = 0;
    while (done_q.size() < target && k < budget) begin
      @(negedge clk_4MHz); #1; k++;
    end
    check(tag, done_q.size(), target);
  endtask

  task automatic wait_cmds(input int target, input int budget, input string tag);
    int k = 0;
    while (cmd_q.size() < target && k < budget) begin
      @(negedge clk_4MHz); #1; k++;
    end
    check(tag, cmd_q.size(), target);
  endtask

  logic [10:0] exp1[5]  = '{11'h000, 11'h1A0, 11'h110, 11'h1AC, 11'h400};
  logic [10:0] exp2[14] = '{11'h000, 11'h1A0, 11'h150, 11'h500, 11'h1A1,
                            11'h200, 11'h200, 11'h200, 11'h200, 11'h200, 11'h200, 11'h200,
                            11'h300, 11'h400};

  initial begin
    int cb, rb, db, ab;
    logic [7:0] d;
    rst = 1'b1; eng_cmd_ready = 1'b1; nack_en = 1'b0; nack_byte = '0;
    req_rw = '0; req_dev = '0; req_reg = '0; req_wdata = '0; req_len = '0;
    repeat (3) @(negedge clk_4MHz);
    #1;
    check("reset_outs", outs(), 32'h0);
    rst = 1'b0;

    // 1: req0 single-byte write
    cb = cmd_q.size(); rb = rd_q.size(); db = done_q.size();
    set_req(0, 1'b0, 7'h50, 8'h10, 8'hAC, 4'd0);
    wait_dones(db + 1, 200, "t1_done_wait");
    check("t1_ncmds", cmd_q.size() - cb, 5);
    for (int k = 0; k < 5; k++) check($sformatf("t1_cmd%0d", k), cmd_q[cb + k], exp1[k]);
    check("t1_done", done_q[db], 8'h01);
    check("t1_latency", cmd_t[cb] - t_req, 2);
    check("t1_no_rd", rd_q.size() - rb, 0);

    // 2: req1 8-byte read
    cb = cmd_q.size(); rb = rd_q.size(); db = done_q.size();
    set_req(1, 1'b1, 7'h50, 8'h50, 8'h00, 4'd7);
    wait_dones(db + 1, 300, "t2_done_wait");
    check("t2_ncmds", cmd_q.size() - cb, 14);
    for (int k = 0; k < 14; k++) check($sformatf("t2_cmd%0d", k), cmd_q[cb + k], exp2[k]);
    check("t2_nrd", rd_q.size() - rb, 8);
    for (int k = 0; k < 8; k++) begin
      d = 8'(32'h85 + cb + k);
      check($sformatf("t2_rd%0d", k), rd_q[rb + k], {3'd1, (k == 7), d});
    end
    check("t2_done", done_q[db], 8'h12);

    // 3: both requesters from reset, each holding for two transactions
    rst = 1'b1;
    repeat (2) @(negedge clk_4MHz);
    #1;
    rst = 1'b0;
    cb = cmd_q.size(); db = done_q.size();
    set_req(0, 1'b0, 7'h50, 8'h10, 8'hAC, 4'd0);
    set_req(0, 1'b0, 7'h50, 8'h10, 8'hAC, 4'd0);
    set_req(1, 1'b0, 7'h21, 8'h02, 8'h33, 4'd0);
    set_req(1, 1'b0, 7'h21, 8'h02, 8'h33, 4'd0);
    wait_dones(db + 4, 600, "t3_done_wait");
    for (int k = 0; k < 4; k++)
      check($sformatf("t3_order%0d", k), done_q[db + k], (k % 2 == 0) ? 8'h01 : 8'h12);
    check("t3_r1_dev", cmd_q[cb + 6], 11'h142);
    check("t3_r1_data", cmd_q[cb + 8], 11'h133);

    // 4: device-address NACK on a read
    nack_en = 1'b1; nack_byte = 8'hA0;
    cb = cmd_q.size(); rb = rd_q.size(); db = done_q.size();
    set_req(0, 1'b1, 7'h50, 8'h10, 8'h00, 4'd3);
    wait_dones(db + 1, 200, "t4_done_wait");
    check("t4_ncmds", cmd_q.size() - cb, 3);
    check("t4_devw", cmd_q[cb + 1], 11'h1A0);
    check("t4_stop", cmd_q[cb + 2], 11'h400);
    check("t4_done", done_q[db], 8'h05);
    check("t4_no_rd", rd_q.size() - rb, 0);
    nack_en = 1'b0;

    // 5: engine never ready -> timeout abort
    eng_cmd_ready = 1'b0;
    cb = cmd_q.size(); db = done_q.size(); ab = abort_cnt;
    set_req(0, 1'b0, 7'h50, 8'h10, 8'hAC, 4'd0);
    wait_dones(db + 1, TIMEOUT_CYC + 50, "t5_done_wait");
    check("t5_done", done_q[db], 8'h89);
    check("t5_aborts", abort_cnt - ab, 1);
    check("t5_duration", done_t[db] - t_req, TIMEOUT_CYC + 2);
    check("t5_no_cmd", cmd_q.size() - cb, 0);
    @(negedge clk_4MHz); #1;
    check("t5_idle_after", {eng_cmd_valid, txn_done, eng_abort}, 0);
    eng_cmd_ready = 1'b1;

    // 6: reset during third read byte
    cb = cmd_q.size(); rb = rd_q.size(); db = done_q.size();
    set_req(0, 1'b1, 7'h50, 8'h10, 8'h00, 4'd7);
    wait_cmds(cb + 8, 200, "t6_cmd_wait");
    check("t6_pre_rd", rd_q.size() - rb, 2);
    rst = 1'b1;
    n_issue[0] = n_done[0];
    @(negedge clk_4MHz); #1;
    check("t6_rst_outs", outs(), 32'h0);
    repeat (2) @(negedge clk_4MHz);
    #1;
    rst = 1'b0;
    repeat (5) @(negedge clk_4MHz);
    #1;
    check("t6_no_done", done_q.size() - db, 0);
    set_req(1, 1'b0, 7'h21, 8'h02, 8'h33, 4'd0);
    set_req(0, 1'b0, 7'h50, 8'h10, 8'hAC, 4'd0);
    wait_dones(db + 2, 400, "t6_done_wait");
    check("t6_first_grant", done_q[db], 8'h01);
    check("t6_second_grant", done_q[db + 1], 8'h12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
